// File: rtl/adma_dm_pkg.sv
// Shared types and helpers for the datamover buffer-port arbitration logic.
package adma_dm_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_e;

  localparam int CH_NUM_DEF = 4;
  localparam int DATA_W_DEF = 256;

  // Channel-id width; a single channel still needs one id bit.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adma_rr_picker.sv
// Combinational round-robin select: first set request at or above ptr, wrapping.
module adma_rr_picker
  import adma_dm_pkg::*;
#(
  parameter int CH_NUM = CH_NUM_DEF,
  localparam int ID_W  = id_w(CH_NUM)
) (
  input  logic [CH_NUM-1:0] req,
  input  logic [ID_W-1:0]   ptr,
  output logic              any,
  output logic [ID_W-1:0]   idx
);

  logic [ID_W:0] cand;

  // Walk offsets from the farthest down to ptr so the nearest request wins.
  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int i = CH_NUM - 1; i >= 0; i--) begin
      cand = {1'b0, ptr} + (ID_W + 1)'(i);
      if (cand >= (ID_W + 1)'(CH_NUM)) begin
        cand = cand - (ID_W + 1)'(CH_NUM);
      end
      if (req[cand[ID_W-1:0]]) begin
        any = 1'b1;
        idx = cand[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/adma_dm_buf_arb.sv
// Burst-granular round-robin arbiter steering one channel's read-data stream
// onto the shared data buffer write port, with a channel-id sideband.
//
// state | meaning
// IDLE  | no grant; arbitrate enabled requests from ptr (1-cycle bubble)
// XFER  | grant_id owns the buffer port until its last beat is accepted
module adma_dm_buf_arb
  import adma_dm_pkg::*;
#(
  parameter int CH_NUM = CH_NUM_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = 8,
  localparam int ID_W  = id_w(CH_NUM)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CH_NUM-1:0]        ch_en,
  input  logic [CH_NUM*DATA_W-1:0] src_data,
  input  logic [CH_NUM-1:0]        src_vld,
  input  logic [CH_NUM-1:0]        src_last,
  output logic [CH_NUM-1:0]        src_rdy,
  output logic [DATA_W-1:0]        buf_data,
  output logic                     buf_vld,
  output logic                     buf_last,
  output logic [ID_W-1:0]          buf_id,
  input  logic                     buf_rdy,
  output logic                     grant_vld,
  output logic [ID_W-1:0]          grant_id,
  output logic [CNT_W-1:0]         beat_cnt
);

  arb_state_e      state;
  logic [ID_W-1:0] ptr;
  logic            pick_any;
  logic [ID_W-1:0] pick_idx;
  logic            xfer_act;
  logic            beat_acc;

  adma_rr_picker #(.CH_NUM(CH_NUM)) u_pick (
    .req (src_vld & ch_en),
    .ptr (ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  // Port is blanked during reset so no beat can complete in the reset cycle.
  assign xfer_act = (state == XFER) && !rst;
  assign buf_id   = grant_id;
  assign beat_acc = buf_vld & buf_rdy;

  always_comb begin
    src_rdy  = '0;
    buf_vld  = 1'b0;
    buf_last = 1'b0;
    buf_data = '0;
    if (xfer_act) begin
      buf_vld           = src_vld[grant_id];
      buf_last          = src_last[grant_id];
      buf_data          = src_data[int'(grant_id) * DATA_W +: DATA_W];
      src_rdy[grant_id] = buf_rdy;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grant_vld <= 1'b0;
      grant_id  <= '0;
      beat_cnt  <= '0;
      ptr       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            state     <= XFER;
            grant_vld <= 1'b1;
            grant_id  <= pick_idx;
            beat_cnt  <= '0;
          end
        end
        XFER: begin
          if (beat_acc) begin
            if (buf_last) begin
              state     <= IDLE;
              grant_vld <= 1'b0;
              beat_cnt  <= '0;
              ptr       <= (grant_id == ID_W'(CH_NUM - 1)) ? '0 : grant_id + ID_W'(1);
            end else if (beat_cnt != '1) begin
              beat_cnt <= beat_cnt + CNT_W'(1);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adma_dm_buf_arb.sv
// Scoreboard bench for adma_dm_buf_arb: per-channel beat sources plus an
// expected-beat queue checked by an independent monitor.
module tb_adma_dm_buf_arb;

  localparam int CH = 4;
  localparam int DW = 32;
  localparam int CW = 2;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  typedef struct packed {
    logic [1:0]    id;
    logic [DW-1:0] data;
    logic          last;
    logic [CW-1:0] cnt;
    logic [CH-1:0] rdy;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [CH-1:0]    ch_en;
  logic [CH*DW-1:0] src_data;
  logic [CH-1:0]    src_vld;
  logic [CH-1:0]    src_last;
  logic [CH-1:0]    src_rdy;
  logic [DW-1:0]    buf_data;
  logic             buf_vld;
  logic             buf_last;
  logic [1:0]       buf_id;
  logic             buf_rdy;
  logic             grant_vld;
  logic [1:0]       grant_id;
  logic [CW-1:0]    beat_cnt;

  adma_dm_buf_arb #(.CH_NUM(CH), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .ch_en     (ch_en),
    .src_data  (src_data),
    .src_vld   (src_vld),
    .src_last  (src_last),
    .src_rdy   (src_rdy),
    .buf_data  (buf_data),
    .buf_vld   (buf_vld),
    .buf_last  (buf_last),
    .buf_id    (buf_id),
    .buf_rdy   (buf_rdy),
    .grant_vld (grant_vld),
    .grant_id  (grant_id),
    .beat_cnt  (beat_cnt)
  );

  always #5 clk = ~clk;

  beat_t chq[CH][$];
  exp_t  expq[$];
  exp_t  mon_got;
  exp_t  mon_exp;
  int    n_pass = 0;
  int    n_total = 0;

  logic          rst_set;
  logic          rdy_set;
  logic [CH-1:0] en_set;
  logic [CH-1:0] hold;

  task automatic chk(input string name, input int act, input int exp_v);
    n_total++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", name, act, exp_v);
  endtask

  // One cycle: drive at negedge, retire handshaken source beats at +1,
  // monitor samples at +2, caller resumes at +3 (before the next posedge).
  task automatic step();
    @(negedge clk);
    rst     = rst_set;
    buf_rdy = rdy_set;
    ch_en   = en_set;
    for (int i = 0; i < CH; i++) begin
      if (chq[i].size() != 0 && !hold[i]) begin
        src_vld[i]            = 1'b1;
        src_data[i*DW +: DW]  = chq[i][0].data;
        src_last[i]           = chq[i][0].last;
      end else begin
        src_vld[i]            = 1'b0;
        src_data[i*DW +: DW]  = '0;
        src_last[i]           = 1'b0;
      end
    end
    #1;
    for (int i = 0; i < CH; i++) begin
      if (src_vld[i] && src_rdy[i]) void'(chq[i].pop_front());
    end
    #2;
  endtask

  task automatic push_burst(input int ch, input int n, input logic [7:0] tag, input int nexp);
    beat_t b;
    exp_t  e;
    for (int k = 0; k < n; k++) begin
      b.data = {8'(ch), tag, 16'(k)};
      b.last = (k == n - 1);
      chq[ch].push_back(b);
      if (k < nexp) begin
        e.id   = 2'(ch);
        e.data = b.data;
        e.last = b.last;
        e.cnt  = (k > 3) ? 2'd3 : 2'(k);
        e.rdy  = 4'b0001 << ch;
        expq.push_back(e);
      end
    end
  endtask

  task automatic drain(input string name, input int max, output int n);
    n = 0;
    while (expq.size() != 0 && n < max) begin
      step();
      n++;
    end
    chk({name, "_drained"}, expq.size(), 0);
    expq.delete();
  endtask

  // Monitor: every accepted buffer beat must match the head of the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (buf_vld && buf_rdy) begin
        mon_got = '{id: buf_id, data: buf_data, last: buf_last, cnt: beat_cnt, rdy: src_rdy};
        n_total++;
        if (expq.size() == 0) begin
          $display("FAIL beat_unexpected: got id=%0d data=%h last=%0d, want no beat",
                   buf_id, buf_data, buf_last);
        end else begin
          mon_exp = expq.pop_front();
          if (mon_got == mon_exp) n_pass++;
          else $display("FAIL beat: got id=%0d data=%h last=%0d cnt=%0d rdy=%b, want id=%0d data=%h last=%0d cnt=%0d rdy=%b",
                        mon_got.id, mon_got.data, mon_got.last, mon_got.cnt, mon_got.rdy,
                        mon_exp.id, mon_exp.data, mon_exp.last, mon_exp.cnt, mon_exp.rdy);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  logic [6:0] bp_rdy;
  logic [6:0] bp_hold;

  initial begin
    int n;
    rst = 1'b1; buf_rdy = 1'b0; ch_en = '1;
    src_data = '0; src_vld = '0; src_last = '0;
    rst_set = 1'b1; rdy_set = 1'b0; en_set = '1; hold = '0;

    repeat (3) step();
    chk("rst_grant_vld", grant_vld, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_beat_cnt", beat_cnt, 0);
    chk("rst_src_rdy", src_rdy, 0);
    chk("rst_buf_vld", buf_vld, 0);
    rst_set = 1'b0;
    rdy_set = 1'b1;

    // Single 4-beat request on ch2.
    push_burst(2, 4, 8'h11, 4);
    step();
    chk("t1_bubble_grant_vld", grant_vld, 0);
    chk("t1_bubble_src_rdy", src_rdy, 0);
    step();
    chk("t1_grant_vld", grant_vld, 1);
    chk("t1_grant_id", grant_id, 2);
    drain("t1", 20, n);
    chk("t1_rest_cycles", n, 3);
    step();
    chk("t1_idle_grant_vld", grant_vld, 0);
    chk("t1_idle_beat_cnt", beat_cnt, 0);

    // ptr is now 3: ch3 must beat ch0.
    push_burst(3, 2, 8'h12, 2);
    push_burst(0, 2, 8'h13, 2);
    drain("t1_ptr", 30, n);
    chk("t1_ptr_cycles", n, 6);

    // Rotation from a fresh pointer.
    rst_set = 1'b1; step(); rst_set = 1'b0;
    push_burst(0, 2, 8'h20, 2);
    push_burst(1, 2, 8'h21, 2);
    push_burst(2, 2, 8'h22, 2);
    push_burst(3, 2, 8'h23, 2);
    push_burst(0, 2, 8'h24, 2);
    for (int s = 1; s <= 15; s++) begin
      step();
      chk("rot_grant_vld", grant_vld, (s % 3 != 1) ? 1 : 0);
    end
    chk("rot_all_beats", expq.size(), 0);

    // Backpressure and source gaps on ch1.
    bp_rdy  = 7'b1111001;
    bp_hold = 7'b0011000;
    push_burst(1, 3, 8'h30, 3);
    step();
    for (int k = 0; k < 7; k++) begin
      rdy_set = bp_rdy[k];
      hold    = bp_hold[k] ? 4'b0010 : 4'b0000;
      step();
      chk("bp_grant_vld", grant_vld, 1);
      chk("bp_grant_id", grant_id, 1);
      chk("bp_other_rdy", src_rdy & 4'b1101, 0);
    end
    hold = '0; rdy_set = 1'b1;
    step();
    chk("bp_end_grant_vld", grant_vld, 0);
    chk("bp_all_beats", expq.size(), 0);

    // Enable mask 1010 with everyone requesting; ptr=2 so ch3 leads.
    en_set = 4'b1010;
    push_burst(0, 2, 8'h40, 0);
    push_burst(2, 2, 8'h41, 0);
    push_burst(3, 2, 8'h42, 2);
    push_burst(1, 2, 8'h43, 2);
    push_burst(3, 2, 8'h44, 2);
    push_burst(1, 2, 8'h45, 2);
    drain("en", 40, n);
    chk("en_cycles", n, 12);

    // Clearing ch_en[1] mid-burst must not cut the burst short.
    push_burst(1, 3, 8'h50, 3);
    step();
    step();
    chk("enm_grant_id", grant_id, 1);
    en_set = 4'b1000;
    drain("enm", 10, n);
    chk("enm_cycles", n, 2);
    step();
    chk("enm_idle_grant_vld", grant_vld, 0);
    chq[0].delete();
    chq[2].delete();
    en_set = '1;

    // Reset on beat 2 of a 5-beat ch0 burst.
    push_burst(0, 5, 8'h60, 2);
    step();
    step();
    step();
    rst_set = 1'b1;
    step();
    chk("rmb_rst_src_rdy", src_rdy, 0);
    rst_set = 1'b0;
    chq[0].delete();
    step();
    chk("rmb_grant_vld", grant_vld, 0);
    chk("rmb_beat_cnt", beat_cnt, 0);
    chk("rmb_src_rdy", src_rdy, 0);
    chk("rmb_no_extra", expq.size(), 0);
    push_burst(1, 2, 8'h71, 2);
    push_burst(3, 2, 8'h70, 2);
    drain("rmb_ptr", 20, n);
    chk("rmb_ptr_cycles", n, 6);

    // Single-beat bursts.
    push_burst(0, 1, 8'h80, 1);
    push_burst(3, 1, 8'h81, 1);
    drain("single", 20, n);
    chk("single_cycles", n, 4);
    step();
    chk("single_idle", grant_vld, 0);

    // Counter saturation with a 2-bit counter.
    push_burst(2, 6, 8'h90, 6);
    drain("sat", 20, n);
    chk("sat_cycles", n, 7);
    step();
    chk("sat_clear_cnt", beat_cnt, 0);
    chk("sat_idle", grant_vld, 0);

    repeat (2) step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
